// File: rtl/idex_pipe_reg.sv
// ID/EX pipeline register with valid bit, stall/flush and load-use hazard bubbles.
// Optional IDEX_PERF_CNT_EN adds saturating bubble/hold event counters.
module idex_pipe_reg #(
    parameter int unsigned DATA_WIDTH       = 57,
    parameter int unsigned REG_ADDR_W       = 6,
    parameter int unsigned EX_CTRL_W        = 4,
    parameter int unsigned MEM_CTRL_W       = 3,
    parameter int unsigned WB_CTRL_W        = 2,
    parameter int unsigned MEM_READ_BIT     = 0,
    parameter int unsigned LOAD_USE_BUBBLES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid_in,
    input  logic [DATA_WIDTH-1:0] id_data_in,
    input  logic [REG_ADDR_W-1:0] id_rd_in,
    input  logic [REG_ADDR_W-1:0] id_rs_in,
    input  logic [REG_ADDR_W-1:0] id_rt_in,
    input  logic [EX_CTRL_W-1:0]  id_ex_ctrl_in,
    input  logic [MEM_CTRL_W-1:0] id_mem_ctrl_in,
    input  logic [WB_CTRL_W-1:0]  id_wb_ctrl_in,
    input  logic                  ext_stall_in,
    input  logic                  flush_in,
    output logic                  ex_valid_out,
    output logic [DATA_WIDTH-1:0] ex_data_out,
    output logic [REG_ADDR_W-1:0] ex_rd_out,
    output logic [REG_ADDR_W-1:0] ex_rs_out,
    output logic [REG_ADDR_W-1:0] ex_rt_out,
    output logic [EX_CTRL_W-1:0]  ex_ctrl_out,
    output logic [MEM_CTRL_W-1:0] mem_ctrl_out,
    output logic [WB_CTRL_W-1:0]  wb_ctrl_out,
    output logic                  hazard_stall_out
`ifdef IDEX_PERF_CNT_EN
    ,
    output logic [31:0]           perf_bubble_cnt_out,
    output logic [31:0]           perf_hold_cnt_out
`endif
);

    localparam int unsigned BUB_W = 3;

    logic                  detect_c;
    logic                  capture_c;
    logic                  pass_c;
    logic [BUB_W-1:0]      bub_cnt;
    logic [BUB_W-1:0]      bub_cnt_nxt;
    logic                  valid_nxt;
    logic [DATA_WIDTH-1:0] data_nxt;
    logic [REG_ADDR_W-1:0] rd_nxt;
    logic [REG_ADDR_W-1:0] rs_nxt;
    logic [REG_ADDR_W-1:0] rt_nxt;
    logic [EX_CTRL_W-1:0]  ex_ctrl_nxt;
    logic [MEM_CTRL_W-1:0] mem_ctrl_nxt;
    logic [WB_CTRL_W-1:0]  wb_ctrl_nxt;

    // Load in EX whose destination feeds the instruction in decode; r0 is never a dependency.
    always_comb begin
        detect_c = id_valid_in && ex_valid_out && mem_ctrl_out[MEM_READ_BIT] &&
                   (ex_rd_out != '0) &&
                   ((ex_rd_out == id_rs_in) || (ex_rd_out == id_rt_in));
    end

    assign hazard_stall_out = detect_c | (bub_cnt != '0);

    // Priority: flush > external stall > pending bubbles > new hazard > normal load.
    always_comb begin
        capture_c    = 1'b1;
        pass_c       = 1'b0;
        bub_cnt_nxt  = bub_cnt;
        valid_nxt    = ex_valid_out;
        data_nxt     = ex_data_out;
        rd_nxt       = ex_rd_out;
        rs_nxt       = ex_rs_out;
        rt_nxt       = ex_rt_out;
        ex_ctrl_nxt  = ex_ctrl_out;
        mem_ctrl_nxt = mem_ctrl_out;
        wb_ctrl_nxt  = wb_ctrl_out;

        if (flush_in) begin
            bub_cnt_nxt = '0;
        end else if (ext_stall_in) begin
            capture_c = 1'b0;
        end else if (bub_cnt != '0) begin
            bub_cnt_nxt = bub_cnt - BUB_W'(1);
        end else if (detect_c) begin
            bub_cnt_nxt = BUB_W'(LOAD_USE_BUBBLES - 1);
        end else begin
            pass_c = 1'b1;
        end

        // Bubbles still take data/addresses; only valid and controls are squashed.
        if (capture_c) begin
            data_nxt     = id_data_in;
            rd_nxt       = id_rd_in;
            rs_nxt       = id_rs_in;
            rt_nxt       = id_rt_in;
            valid_nxt    = pass_c && id_valid_in;
            ex_ctrl_nxt  = (pass_c && id_valid_in) ? id_ex_ctrl_in  : '0;
            mem_ctrl_nxt = (pass_c && id_valid_in) ? id_mem_ctrl_in : '0;
            wb_ctrl_nxt  = (pass_c && id_valid_in) ? id_wb_ctrl_in  : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bub_cnt      <= '0;
            ex_valid_out <= 1'b0;
            ex_data_out  <= '0;
            ex_rd_out    <= '0;
            ex_rs_out    <= '0;
            ex_rt_out    <= '0;
            ex_ctrl_out  <= '0;
            mem_ctrl_out <= '0;
            wb_ctrl_out  <= '0;
        end else begin
            bub_cnt      <= bub_cnt_nxt;
            ex_valid_out <= valid_nxt;
            ex_data_out  <= data_nxt;
            ex_rd_out    <= rd_nxt;
            ex_rs_out    <= rs_nxt;
            ex_rt_out    <= rt_nxt;
            ex_ctrl_out  <= ex_ctrl_nxt;
            mem_ctrl_out <= mem_ctrl_nxt;
            wb_ctrl_out  <= wb_ctrl_nxt;
        end
    end

`ifdef IDEX_PERF_CNT_EN
    logic perf_bub_c;
    logic perf_hold_c;

    // A hazard bubble is loaded exactly when stalling for a hazard without flush or hold.
    assign perf_bub_c  = hazard_stall_out && !ext_stall_in && !flush_in;
    assign perf_hold_c = ext_stall_in && !flush_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_bubble_cnt_out <= '0;
            perf_hold_cnt_out   <= '0;
        end else begin
            if (perf_bub_c && (perf_bubble_cnt_out != '1)) begin
                perf_bubble_cnt_out <= perf_bubble_cnt_out + 32'd1;
            end
            if (perf_hold_c && (perf_hold_cnt_out != '1)) begin
                perf_hold_cnt_out <= perf_hold_cnt_out + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_idex_pipe_reg.sv
// Bench for idex_pipe_reg: two instances (1 and 3 load-use bubbles) driven in lockstep.
module tb_idex_pipe_reg;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    typedef struct {
        logic        vld;
        logic [56:0] data;
        logic [5:0]  rd, rs, rt;
        logic [3:0]  ex;
        logic [2:0]  mem;
        logic [1:0]  wb;
        logic        st, fl;
        logic        h1, h3;
        logic        v1;
        logic [8:0]  c1;
        logic        v3;
        logic [8:0]  c3;
    } vec_t;

    logic        clk, rst_n;
    logic        id_valid, ext_stall, flush;
    logic [56:0] id_data;
    logic [5:0]  id_rd, id_rs, id_rt;
    logic [3:0]  id_ex;
    logic [2:0]  id_mem;
    logic [1:0]  id_wb;

    logic        v1_o, v3_o, hz1, hz3;
    logic [56:0] d1_o, d3_o;
    logic [5:0]  rd1_o, rs1_o, rt1_o, rd3_o, rs3_o, rt3_o;
    logic [3:0]  ex1_o, ex3_o;
    logic [2:0]  mem1_o, mem3_o;
    logic [1:0]  wb1_o, wb3_o;
`ifdef IDEX_PERF_CNT_EN
    logic [31:0] pb1, ph1, pb3, ph3;
`endif

    int          checks = 0;
    int          failures = 0;
    vec_t        tbl[25];
    vec_t        exp_q[$];
    logic [56:0] exp_data;
    logic [5:0]  exp_rd, exp_rs, exp_rt;

    idex_pipe_reg #(.LOAD_USE_BUBBLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .id_valid_in(id_valid), .id_data_in(id_data),
        .id_rd_in(id_rd), .id_rs_in(id_rs), .id_rt_in(id_rt), .id_ex_ctrl_in(id_ex),
        .id_mem_ctrl_in(id_mem), .id_wb_ctrl_in(id_wb), .ext_stall_in(ext_stall),
        .flush_in(flush), .ex_valid_out(v1_o), .ex_data_out(d1_o), .ex_rd_out(rd1_o),
        .ex_rs_out(rs1_o), .ex_rt_out(rt1_o), .ex_ctrl_out(ex1_o), .mem_ctrl_out(mem1_o),
        .wb_ctrl_out(wb1_o), .hazard_stall_out(hz1)
`ifdef IDEX_PERF_CNT_EN
        , .perf_bubble_cnt_out(pb1), .perf_hold_cnt_out(ph1)
`endif
    );

    idex_pipe_reg #(.LOAD_USE_BUBBLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .id_valid_in(id_valid), .id_data_in(id_data),
        .id_rd_in(id_rd), .id_rs_in(id_rs), .id_rt_in(id_rt), .id_ex_ctrl_in(id_ex),
        .id_mem_ctrl_in(id_mem), .id_wb_ctrl_in(id_wb), .ext_stall_in(ext_stall),
        .flush_in(flush), .ex_valid_out(v3_o), .ex_data_out(d3_o), .ex_rd_out(rd3_o),
        .ex_rs_out(rs3_o), .ex_rt_out(rt3_o), .ex_ctrl_out(ex3_o), .mem_ctrl_out(mem3_o),
        .wb_ctrl_out(wb3_o), .hazard_stall_out(hz3)
`ifdef IDEX_PERF_CNT_EN
        , .perf_bubble_cnt_out(pb3), .perf_hold_cnt_out(ph3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic vld, input logic [56:0] d, input logic [5:0] rd,
                                input logic [5:0] rs, input logic [5:0] rt, input logic [3:0] ex,
                                input logic [2:0] mem, input logic [1:0] wb, input logic st,
                                input logic fl, input logic h1, input logic h3, input logic v1,
                                input logic [8:0] c1, input logic v3, input logic [8:0] c3);
        vec_t v;
        v.vld = vld; v.data = d; v.rd = rd; v.rs = rs; v.rt = rt;
        v.ex = ex; v.mem = mem; v.wb = wb; v.st = st; v.fl = fl;
        v.h1 = h1; v.h3 = h3; v.v1 = v1; v.c1 = c1; v.v3 = v3; v.c3 = c3;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        id_valid = v.vld; id_data = v.data; id_rd = v.rd; id_rs = v.rs; id_rt = v.rt;
        id_ex = v.ex; id_mem = v.mem; id_wb = v.wb; ext_stall = v.st; flush = v.fl;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " v1"}, 64'(v1_o), 64'd0);
        chk({tag, " v3"}, 64'(v3_o), 64'd0);
        chk({tag, " d1"}, 64'(d1_o), 64'd0);
        chk({tag, " d3"}, 64'(d3_o), 64'd0);
        chk({tag, " addr1"}, 64'({rd1_o, rs1_o, rt1_o}), 64'd0);
        chk({tag, " addr3"}, 64'({rd3_o, rs3_o, rt3_o}), 64'd0);
        chk({tag, " ctrl1"}, 64'({ex1_o, mem1_o, wb1_o}), 64'd0);
        chk({tag, " ctrl3"}, 64'({ex3_o, mem3_o, wb3_o}), 64'd0);
        chk({tag, " hz1"}, 64'(hz1), 64'd0);
        chk({tag, " hz3"}, 64'(hz3), 64'd0);
`ifdef IDEX_PERF_CNT_EN
        chk({tag, " perf1"}, {pb1, ph1}, 64'd0);
        chk({tag, " perf3"}, {pb3, ph3}, 64'd0);
`endif
    endtask

    // Drive at negedge, check stall before the edge, compare registered outputs after it.
    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        @(negedge clk);
        drive(v);
        #1;
        chk($sformatf("v%0d hz1", idx), 64'(hz1), 64'(v.h1));
        chk($sformatf("v%0d hz3", idx), 64'(hz3), 64'(v.h3));
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        if (!e.st || e.fl) begin
            exp_data = e.data; exp_rd = e.rd; exp_rs = e.rs; exp_rt = e.rt;
        end
        chk($sformatf("v%0d valid1", idx), 64'(v1_o), 64'(e.v1));
        chk($sformatf("v%0d ctrl1", idx), 64'({ex1_o, mem1_o, wb1_o}), 64'(e.c1));
        chk($sformatf("v%0d valid3", idx), 64'(v3_o), 64'(e.v3));
        chk($sformatf("v%0d ctrl3", idx), 64'({ex3_o, mem3_o, wb3_o}), 64'(e.c3));
        chk($sformatf("v%0d data1", idx), 64'(d1_o), 64'(exp_data));
        chk($sformatf("v%0d data3", idx), 64'(d3_o), 64'(exp_data));
        chk($sformatf("v%0d addr1", idx), 64'({rd1_o, rs1_o, rt1_o}), 64'({exp_rd, exp_rs, exp_rt}));
        chk($sformatf("v%0d addr3", idx), 64'({rd3_o, rs3_o, rt3_o}), 64'({exp_rd, exp_rs, exp_rt}));
    endtask

    initial begin
        // pass-through, load, consumer stall (1 vs 3 bubbles)
        tbl[0]  = mk(H, 57'h1ABCD, 6'd5, 6'd1, 6'd2, 4'hA, 3'b000, 2'b11, L, L, L, L, H, 9'h143, H, 9'h143);
        tbl[1]  = mk(H, 57'h100, 6'd7, 6'd3, 6'd4, 4'h1, 3'b001, 2'b01, L, L, L, L, H, 9'h025, H, 9'h025);
        tbl[2]  = mk(H, 57'h200, 6'd8, 6'd7, 6'd0, 4'h2, 3'b000, 2'b10, L, L, H, H, L, 9'h0, L, 9'h0);
        tbl[3]  = mk(H, 57'h200, 6'd8, 6'd7, 6'd0, 4'h2, 3'b000, 2'b10, L, L, L, H, H, 9'h042, L, 9'h0);
        tbl[4]  = mk(H, 57'h200, 6'd8, 6'd7, 6'd0, 4'h2, 3'b000, 2'b10, L, L, L, H, H, 9'h042, L, 9'h0);
        tbl[5]  = mk(H, 57'h200, 6'd8, 6'd7, 6'd0, 4'h2, 3'b000, 2'b10, L, L, L, L, H, 9'h042, H, 9'h042);
        // rd=0 load and non-load producer never stall
        tbl[6]  = mk(H, 57'h300, 6'd0, 6'd9, 6'd9, 4'h3, 3'b001, 2'b00, L, L, L, L, H, 9'h064, H, 9'h064);
        tbl[7]  = mk(H, 57'h400, 6'd10, 6'd0, 6'd0, 4'h4, 3'b000, 2'b01, L, L, L, L, H, 9'h081, H, 9'h081);
        tbl[8]  = mk(H, 57'h500, 6'd7, 6'd1, 6'd1, 4'h5, 3'b010, 2'b00, L, L, L, L, H, 9'h0A8, H, 9'h0A8);
        tbl[9]  = mk(H, 57'h600, 6'd11, 6'd7, 6'd7, 4'h6, 3'b000, 2'b11, L, L, L, L, H, 9'h0C3, H, 9'h0C3);
        // flush on second bubble aborts the sequence
        tbl[10] = mk(H, 57'h700, 6'd12, 6'd2, 6'd3, 4'h7, 3'b001, 2'b01, L, L, L, L, H, 9'h0E5, H, 9'h0E5);
        tbl[11] = mk(H, 57'h800, 6'd13, 6'd4, 6'd12, 4'h8, 3'b000, 2'b10, L, L, H, H, L, 9'h0, L, 9'h0);
        tbl[12] = mk(H, 57'h800, 6'd13, 6'd4, 6'd12, 4'h8, 3'b000, 2'b10, L, H, L, H, L, 9'h0, L, 9'h0);
        tbl[13] = mk(H, 57'h800, 6'd13, 6'd4, 6'd12, 4'h8, 3'b000, 2'b10, L, L, L, L, H, 9'h102, H, 9'h102);
        // ext stall holding valid data, then holding a bubble with count pending
        tbl[14] = mk(H, 57'h900, 6'd14, 6'd5, 6'd6, 4'h9, 3'b011, 2'b11, L, L, L, L, H, 9'h12F, H, 9'h12F);
        tbl[15] = mk(H, 57'hA00, 6'd15, 6'd14, 6'd0, 4'hB, 3'b000, 2'b01, H, L, H, H, H, 9'h12F, H, 9'h12F);
        tbl[16] = mk(H, 57'hA00, 6'd15, 6'd14, 6'd0, 4'hB, 3'b000, 2'b01, L, L, H, H, L, 9'h0, L, 9'h0);
        for (int i = 17; i <= 20; i++)
            tbl[i] = mk(H, 57'hBAD, 6'd20, 6'd14, 6'd14, 4'hB, 3'b000, 2'b01, H, L, L, H, L, 9'h0, L, 9'h0);
        tbl[21] = mk(H, 57'hA00, 6'd15, 6'd14, 6'd0, 4'hB, 3'b000, 2'b01, L, L, L, H, H, 9'h161, L, 9'h0);
        tbl[22] = mk(H, 57'hA00, 6'd15, 6'd14, 6'd0, 4'hB, 3'b000, 2'b01, L, L, L, H, H, 9'h161, L, 9'h0);
        tbl[23] = mk(H, 57'hA00, 6'd15, 6'd14, 6'd0, 4'hB, 3'b000, 2'b01, L, L, L, L, H, 9'h161, H, 9'h161);
        // invalid decode slot: controls zeroed
        tbl[24] = mk(L, 57'hC00, 6'd7, 6'd15, 6'd15, 4'hF, 3'b111, 2'b11, L, L, L, L, L, 9'h0, L, 9'h0);

        // Reset with non-zero inputs: everything must read zero.
        rst_n = 1'b0;
        drive(tbl[1]);
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        drive(mk(L, 57'h0, 6'd0, 6'd0, 6'd0, 4'h0, 3'b000, 2'b00, L, L, L, L, L, 9'h0, L, 9'h0));
        rst_n = 1'b1;
        exp_data = '0; exp_rd = '0; exp_rs = '0; exp_rt = '0;

        for (int i = 0; i < 25; i++) apply(tbl[i], i);

`ifdef IDEX_PERF_CNT_EN
        chk("perf_bub1", 64'(pb1), 64'd3);
        chk("perf_bub3", 64'(pb3), 64'd7);
        chk("perf_hold1", 64'(ph1), 64'd5);
        chk("perf_hold3", 64'(ph3), 64'd5);
`endif

        // Asynchronous reset in the middle of a 3-bubble sequence clears it.
        apply(mk(H, 57'hD00, 6'd7, 6'd1, 6'd2, 4'h1, 3'b001, 2'b01, L, L, L, L, H, 9'h025, H, 9'h025), 100);
        apply(mk(H, 57'hE00, 6'd9, 6'd7, 6'd7, 4'h2, 3'b000, 2'b10, L, L, H, H, L, 9'h0, L, 9'h0), 101);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        exp_data = '0; exp_rd = '0; exp_rs = '0; exp_rt = '0;
        apply(mk(H, 57'hE00, 6'd9, 6'd7, 6'd7, 4'h2, 3'b000, 2'b10, L, L, L, L, H, 9'h042, H, 9'h042), 102);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/idex_pipe_reg.md
Name: idex_pipe_reg

Overview:
- Parametrised ID/EX pipeline register. Next generation of the fixed-width decode/execute register.
- Adds a valid bit, external stall (hold), flush (bubble), and built-in load-use hazard detection.
- Load-use bubble count is configurable, so multi-cycle memories are covered.
- Sits between decode and execute. Its hazard_stall_out drives the PC/IF-ID hold logic.

Parameters:
- DATA_WIDTH, 57, width of the operand/immediate bundle.
- REG_ADDR_W, 6, register address width.
- EX_CTRL_W, 4, execute control width.
- MEM_CTRL_W, 3, memory control width.
- WB_CTRL_W, 2, writeback control width.
- MEM_READ_BIT, 0, bit index of the load flag within mem_ctrl.
- LOAD_USE_BUBBLES, 1, bubbles inserted per load-use hazard; legal range 1..7.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid_in  in  1  decode slot holds a real instruction.
- id_data_in  in  DATA_WIDTH  operand bundle from decode.
- id_rd_in  in  REG_ADDR_W  destination register.
- id_rs_in  in  REG_ADDR_W  source register 1.
- id_rt_in  in  REG_ADDR_W  source register 2.
- id_ex_ctrl_in  in  EX_CTRL_W  execute controls.
- id_mem_ctrl_in  in  MEM_CTRL_W  memory controls.
- id_wb_ctrl_in  in  WB_CTRL_W  writeback controls.
- ext_stall_in  in  1  downstream stall; hold all state.
- flush_in  in  1  branch/exception flush.
- ex_valid_out  out  1  registered valid.
- ex_data_out  out  DATA_WIDTH  registered bundle.
- ex_rd_out, ex_rs_out, ex_rt_out  out  REG_ADDR_W each  registered addresses.
- ex_ctrl_out  out  EX_CTRL_W  registered execute controls.
- mem_ctrl_out  out  MEM_CTRL_W  registered memory controls.
- wb_ctrl_out  out  WB_CTRL_W  registered writeback controls.
- hazard_stall_out  out  1  combinational; freezes PC and IF/ID.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all outputs and the internal bubble counter go to 0;
  - ex_valid_out=0;
  - hazard_stall_out=0 while in reset.
- Latency: 1 cycle. Inputs are captured on the posedge; outputs are plain register outputs, no bypass.
- Bubble: ex_valid_out=0 and ex_ctrl/mem_ctrl/wb_ctrl=0. Data and addresses are loaded from the inputs (don't care downstream).
- Hazard detect (combinational) is true when all of the following hold:
  - id_valid_in=1;
  - ex_valid_out=1;
  - mem_ctrl_out[MEM_READ_BIT]=1;
  - ex_rd_out!=0;
  - ex_rd_out==id_rs_in or ex_rd_out==id_rt_in.
- Register 0 never causes a hazard.
- Bubble counter bub_cnt: 3 bits. hazard_stall_out = detect | (bub_cnt!=0).
- Per-edge priority:
  1. flush_in=1: load bubble, bub_cnt<=0. Overrides stall and hazard.
  2. ext_stall_in=1: hold every register and bub_cnt unchanged. hazard_stall_out stays combinational.
  3. bub_cnt!=0: load bubble, bub_cnt<=bub_cnt-1.
  4. detect=1: load bubble, bub_cnt<=LOAD_USE_BUBBLES-1.
  5. Otherwise: load inputs, ex_valid_out<=id_valid_in. Controls are zeroed when id_valid_in=0.
- Upstream holds the decode instruction while hazard_stall_out=1. After exactly LOAD_USE_BUBBLES bubbles it is accepted.
- Flush during a bubble sequence aborts the sequence. Reset mid-sequence clears everything.
- Back-to-back loads:
  - each dependent consumer gets its own LOAD_USE_BUBBLES bubbles;
  - a non-dependent instruction following a load passes with no bubble.

Optional Feature:
IDEX_PERF_CNT_EN:
- When defined, adds output ports perf_bubble_cnt_out[31:0] and perf_hold_cnt_out[31:0].
  - perf_bubble_cnt_out counts edges where a hazard bubble is loaded (priorities 3 and 4).
  - perf_hold_cnt_out counts edges with ext_stall_in=1 and flush_in=0.
  - Both reset to 0 asynchronously and saturate at 32'hFFFFFFFF.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset/pass-through: release rst_n; present valid, data=57'h1ABCD, rd=5, ex=4'hA, mem=3'b000, wb=2'b11 → next cycle outputs equal the inputs with ex_valid_out=1. While rst_n=0, all outputs are 0.
- Load-use, LOAD_USE_BUBBLES=1: load rd=7 in EX (mem=3'b001); decode rs=7 → hazard_stall_out=1 for 1 cycle. One bubble is loaded (valid=0, controls 0). The consumer enters the next cycle.
- Multi-bubble, LOAD_USE_BUBBLES=3: same hazard → hazard_stall_out high for 3 cycles, 3 consecutive bubbles, then the consumer with valid=1.
- rd=0 or non-load: load with rd=0 and rs=0 in decode → no stall. Non-load rd=7 with rs=7 → no stall.
- Flush mid-sequence, LOAD_USE_BUBBLES=3: assert flush_in on the 2nd bubble cycle → bub_cnt=0, hazard_stall_out=0 next cycle (if no new hazard), bubble loaded.
- Ext stall: ext_stall_in=1 for 4 cycles with the pipe holding valid data, plus an active bubble count → outputs and bub_cnt frozen. With IDEX_PERF_CNT_EN, perf_hold_cnt_out=4.
